// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
// The arbiter takes the slave side; the requesters (or a bench) take the master side.
interface rr_dec_arbiter_if #(
    parameter int NREQ  = 16,
    parameter int IDX_W = 4
) ();
    logic             en;
    logic [NREQ-1:0]  req;
    logic             done;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic             timeout;

    modport master (
        output en, req, done,
        input  grant, grant_idx, grant_vld, timeout
    );

    modport slave (
        input  en, req, done,
        output grant, grant_idx, grant_vld, timeout
    );
endinterface

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter handing one decoded select bus to NREQ requesters, one owner at a time.
// A grant lasts until done, request drop, or the MAX_HOLD timeout; each release costs one idle cycle.
module rr_dec_arbiter #(
    parameter int NREQ     = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_dec_arbiter_if.slave bus
);
    localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_ptr, w_ptr_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [NREQ-1:0]  r_grant, w_grant_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic             r_vld, w_vld_next;
    logic             r_timeout, w_timeout_next;
    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             w_any;
    logic [IDX_W-1:0] w_winner;
    logic             w_hold_hit;
    logic             w_release;

    // Reset asserts asynchronously but leaves at a clock edge, so the first edge after
    // rst_n rises still sees the block in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[r_ptr + IDX_W'(k)]) begin
                w_any    = 1'b1;
                w_winner = r_ptr + IDX_W'(k);
            end
        end
    end

    assign w_hold_hit = (MAX_HOLD != 0) && (r_cnt == HOLD_LIM);
    assign w_release  = bus.done || !bus.req[r_idx] || w_hold_hit;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_idx     <= '0;
            r_vld     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_cnt     <= w_cnt_next;
            r_grant   <= w_grant_next;
            r_idx     <= w_idx_next;
            r_vld     <= w_vld_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.en && w_any) w_state_next = BUSY;
            BUSY:    if (w_release)       w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_ptr_next     = r_ptr;
        w_cnt_next     = r_cnt;
        w_grant_next   = r_grant;
        w_idx_next     = r_idx;
        w_vld_next     = r_vld;
        w_timeout_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en && w_any) begin
                    w_vld_next   = 1'b1;
                    w_idx_next   = w_winner;
                    w_grant_next = NREQ'(1) << w_winner;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_vld_next     = 1'b0;
                    w_grant_next   = '0;
                    w_ptr_next     = r_idx + IDX_W'(1);
                    w_cnt_next     = '0;
                    // A limit hit is reported even when done arrives in the same cycle.
                    w_timeout_next = w_hold_hit;
                end else if (MAX_HOLD != 0 && r_cnt != HOLD_LIM) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_idx;
    assign bus.grant_vld = r_vld;
    assign bus.timeout   = r_timeout;
endmodule
